prng_range_sampler: RTL and testbench

Downstream consumer of the 8-bit PRNG byte stream. Converts raw random bytes into unbiased values in [0, limit) by masked rejection sampling, then buffers accepted values in a small FIFO behind a valid/ready output handshake. Sits between the PRNG core and any client (dice, game logic, host readout) that needs bounded random numbers at its own pace.

---
 rtl/prng_range_sampler.sv | 126 ++++++++++++
 tb/tb_prng_range_sampler.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/prng_range_sampler.sv
// rtl/prng_range_sampler.sv - masked rejection sampler turning PRNG bytes into [0, limit) values, FIFO-buffered
module prng_range_sampler #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                rnd_in,
    input  logic                      rnd_valid,
    output logic                      rnd_ready,
    input  logic                      cfg_we,
    input  logic [7:0]                cfg_limit,
    output logic [7:0]                out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level,
    output logic [CNT_W-1:0]          reject_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Smallest all-ones mask covering limit-1, so a masked byte lands below limit at least half the time.
    function automatic logic [7:0] mask_for(input logic [7:0] lim);
        logic [7:0] v;
        v = lim - 8'd1;
        v = v | (v >> 1);
        v = v | (v >> 2);
        v = v | (v >> 4);
        if (lim == 8'd0) begin
            v = 8'hFF;
        end
        return v;
    endfunction

    logic [7:0]       limit_q, limit_d;
    logic [7:0]       mask_q, mask_d;
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] reject_cnt_q, reject_cnt_d;

    logic       full;
    logic       empty;
    logic [7:0] masked;
    logic       accept;
    logic       push;
    logic       pop;
    logic       reject;

    assign full   = (level_q == LVL_W'(DEPTH));
    assign empty  = (level_q == '0);
    assign masked = rnd_in & mask_q;
    assign accept = (limit_q == 8'd0) || (masked < limit_q);
    assign push   = rnd_valid && !cfg_we && accept && !full;
    assign pop    = !empty && out_ready && !cfg_we;
    assign reject = rnd_valid && !cfg_we && !accept;

    always_comb begin
        limit_d      = limit_q;
        mask_d       = mask_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        reject_cnt_d = reject_cnt_q;
        if (cfg_we) begin
            limit_d      = cfg_limit;
            mask_d       = mask_for(cfg_limit);
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            reject_cnt_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = 8'h00;
            end
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = masked;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                level_d = level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_d = level_q - LVL_W'(1);
            end
            if (reject && (reject_cnt_q != {CNT_W{1'b1}})) begin
                reject_cnt_d = reject_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            limit_q      <= 8'd0;
            mask_q       <= 8'hFF;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            reject_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            limit_q      <= limit_d;
            mask_q       <= mask_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            reject_cnt_q <= reject_cnt_d;
            mem_q        <= mem_d;
        end
    end

    assign out_data   = mem_q[rd_ptr_q];
    assign out_valid  = !empty;
    assign rnd_ready  = !full;
    assign level      = level_q;
    assign reject_cnt = reject_cnt_q;

endmodule

// File: tb/tb_prng_range_sampler.sv
// tb/tb_prng_range_sampler.sv - randomized bench for prng_range_sampler against a queue-based reference model
module tb_prng_range_sampler;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rnd_in;
    logic        rnd_valid;
    logic        rnd_ready;
    logic        cfg_we;
    logic [7:0]  cfg_limit;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic [15:0] reject_cnt;

    prng_range_sampler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rnd_in     (rnd_in),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .cfg_we     (cfg_we),
        .cfg_limit  (cfg_limit),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .reject_cnt (reject_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int q[$];
    int m_limit = 0;
    int m_rej   = 0;
    bit m_clean = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Mask is one less than the smallest power of two that is >= limit.
    function automatic int mask_of(input int lim);
        int p;
        if (lim == 0) return 255;
        p = 1;
        while (p < lim) p = p * 2;
        return p - 1;
    endfunction

    task automatic model_step(input bit r, input bit we, input int lim, input bit rv,
                              input int rin, input bit ordy);
        bit was_full;
        bit can_pop;
        int m;
        bit acc;
        if (r) begin
            q.delete();
            m_limit = 0;
            m_rej   = 0;
            m_clean = 1'b1;
        end else if (we) begin
            q.delete();
            m_limit = lim;
            m_rej   = 0;
            m_clean = 1'b1;
        end else begin
            was_full = (q.size() == DEPTH);
            can_pop  = (q.size() != 0) && ordy;
            m        = rin & mask_of(m_limit);
            acc      = (m_limit == 0) || (m < m_limit);
            if (can_pop) void'(q.pop_front());
            if (rv) begin
                if (!acc) begin
                    if (m_rej < CNT_MAX) m_rej++;
                end else if (!was_full) begin
                    q.push_back(m);
                    m_clean = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        check_eq("out_valid", out_valid, q.size() != 0);
        check_eq("level", level, q.size());
        check_eq("rnd_ready", rnd_ready, q.size() < DEPTH);
        check_eq("reject_cnt", reject_cnt, m_rej);
        if (q.size() != 0) check_eq("out_data", out_data, q[0]);
        else if (m_clean) check_eq("out_data_empty", out_data, 0);
    endtask

    task automatic cyc(input bit r, input bit we, input int lim, input bit rv,
                       input int rin, input bit ordy);
        rst       = r;
        cfg_we    = we;
        cfg_limit = lim[7:0];
        rnd_valid = rv;
        rnd_in    = rin[7:0];
        out_ready = ordy;
        @(posedge clk);
        model_step(r, we, lim, rv, rin, ordy);
        #1;
        compare_outputs();
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_limit = 8'd0;
        rnd_valid = 1'b0; rnd_in = 8'd0; out_ready = 1'b0;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check_eq("reset_level", level, 0);
        check_eq("reset_out_data", out_data, 8'h00);

        // Full range: first byte appears the next cycle
        cyc(0, 0, 0, 1, 8'hA7, 0);
        check_eq("first_data", out_data, 8'hA7);
        check_eq("first_level", level, 1);

        // limit 6: 0x05 and 0x13&7=3 accepted, 6 and 7 rejected
        cyc(0, 1, 6, 0, 0, 0);
        cyc(0, 0, 0, 1, 8'h05, 0);
        cyc(0, 0, 0, 1, 8'h0E, 0);
        cyc(0, 0, 0, 1, 8'h0F, 0);
        cyc(0, 0, 0, 1, 8'h13, 0);
        check_eq("lim6_level", level, 2);
        check_eq("lim6_rej", reject_cnt, 2);
        check_eq("lim6_head", out_data, 8'h05);

        // limit 1: everything accepted as 0, overflow dropped silently
        cyc(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, $urandom_range(0, 255), 0);
        check_eq("lim1_level", level, 4);
        check_eq("lim1_ready", rnd_ready, 0);
        check_eq("lim1_rej", reject_cnt, 0);

        // Full with simultaneous pop: push blocked, then admitted
        cyc(0, 0, 0, 1, 8'h00, 1);
        check_eq("full_pop_level", level, 3);
        cyc(0, 0, 0, 1, 8'h00, 0);
        check_eq("refill_level", level, 4);

        // Flush mid-stream with limit 100
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 8'h10 + i, 0);
        cyc(0, 1, 100, 0, 0, 0);
        check_eq("flush_level", level, 0);
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_data", out_data, 8'h00);
        cyc(0, 0, 0, 1, 8'hE4, 0);
        check_eq("lim100_rej", reject_cnt, 1);
        cyc(0, 0, 0, 1, 8'h63, 0);
        check_eq("lim100_data", out_data, 8'h63);

        // Saturation: 70000 rejects at limit 6
        cyc(0, 1, 6, 0, 0, 0);
        for (int i = 0; i < 70000; i++) cyc(0, 0, 0, 1, 8'h07, 1);
        check_eq("sat_rej", reject_cnt, 16'hFFFF);
        cyc(1, 0, 0, 1, 8'h07, 1);
        check_eq("rst_rej", reject_cnt, 0);
        check_eq("rst_ready", rnd_ready, 1);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            int lim;
            case ($urandom_range(0, 5))
                0: lim = 0;
                1: lim = 1;
                2: lim = 128;
                3: lim = 129;
                default: lim = $urandom_range(0, 255);
            endcase
            cyc($urandom_range(0, 999) == 0, $urandom_range(0, 59) == 0, lim,
                $urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 2) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
